axis2net_sink: RTL and testbench

//  AXI4-Stream slave that sits directly downstream of net2axis and consumes its packet stream.

---
 rtl/axis2net_sink_if.sv | 19 +
 rtl/axis2net_sink.sv | 195 +++++++++++++++++++
 tb/tb_axis2net_sink.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis2net_sink_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | axis2net_sink_if : AXI4-Stream beat bundle (source = master)         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axis2net_sink_if #(
    parameter int C_TDATA_WIDTH = 32
);
    logic                         tvalid;
    logic [C_TDATA_WIDTH-1:0]     tdata;
    logic [C_TDATA_WIDTH/8-1:0]   tkeep;
    logic                         tlast;
    logic                         tready;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis2net_sink.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | axis2net_sink : AXIS sink with backpressure, counters, rule checks   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axis2net_sink #(
    parameter int          C_TDATA_WIDTH = 32,
    parameter int          C_NUM_PKTS    = 1,
    parameter int          C_BP_MODE     = 0,
    parameter logic [15:0] C_LFSR_SEED   = 16'hACE1,
    parameter int          C_CNT_WIDTH   = 32
) (
    input  wire                     ACLK,
    input  wire                     ARESETN,
    axis2net_sink_if.slave          s_axis,
    output logic                    DONE,
    output logic [C_CNT_WIDTH-1:0]  PKT_COUNT,
    output logic [C_CNT_WIDTH-1:0]  BYTE_COUNT,
    output logic [C_CNT_WIDTH-1:0]  LAST_PKT_LEN,
    output logic                    ERR_KEEP,
    output logic                    ERR_STABLE,
    output logic                    ERR_EXTRA
);
    localparam int                   C_KEEP_W       = C_TDATA_WIDTH / 8;
    localparam logic [1:0]           C_ST_IDLE      = 2'd0;
    localparam logic [1:0]           C_ST_IN_PKT    = 2'd1;
    localparam logic [1:0]           C_ST_DONE      = 2'd2;
    localparam logic [C_CNT_WIDTH-1:0] C_CNT_ONE    = C_CNT_WIDTH'(1);
    localparam logic [C_CNT_WIDTH:0] C_EXT_ONE      = (C_CNT_WIDTH+1)'(1);
    localparam logic [C_CNT_WIDTH:0] C_NUM_PKTS_EXT = (C_CNT_WIDTH+1)'(C_NUM_PKTS);

    logic [1:0]               state_q, state_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [1:0]               low_cnt_q, low_cnt_d;
    logic                     tready_q, tready_d;
    logic [C_CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [C_CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [C_CNT_WIDTH-1:0]   last_len_q, last_len_d;
    logic [C_CNT_WIDTH-1:0]   acc_q, acc_d;
    logic                     err_keep_q, err_keep_d;
    logic                     err_stable_q, err_stable_d;
    logic                     err_extra_q, err_extra_d;
    logic                     pend_q, pend_d;
    logic [C_TDATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
    logic [C_KEEP_W-1:0]      shadow_keep_q, shadow_keep_d;
    logic                     shadow_last_q, shadow_last_d;

    logic                     w_accept, w_final, w_keep_ok, w_stable_err;
    logic                     w_cnt_en, w_extra, w_done;
    logic [C_KEEP_W-1:0]      w_keep_inc;
    logic [C_CNT_WIDTH-1:0]   w_beat_bytes;

    assign w_accept = s_axis.tvalid & tready_q;
    assign w_final  = (({1'b0, pkt_cnt_q} + C_EXT_ONE) == C_NUM_PKTS_EXT);

    // Ready generation: LFSR-driven with a forced high after three low cycles.
    if (C_BP_MODE == 1) begin : g_bp_lfsr
        assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        assign tready_d  = lfsr_q[0] | (low_cnt_q == 2'd3);
        assign low_cnt_d = tready_d ? 2'd0 : low_cnt_q + 2'd1;
    end else begin : g_bp_none
        assign lfsr_d    = lfsr_q;
        assign tready_d  = 1'b1;
        assign low_cnt_d = 2'd0;
    end

    always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < C_KEEP_W; i++) begin
            w_beat_bytes = w_beat_bytes + C_CNT_WIDTH'(s_axis.tkeep[i]);
        end
    end

    // A last beat may be partially filled, but only from the LSB upward.
    always_comb begin
        w_keep_inc = s_axis.tkeep + C_KEEP_W'(1);
        if (s_axis.tlast) begin
            w_keep_ok = (s_axis.tkeep != '0) && ((s_axis.tkeep & w_keep_inc) == '0);
        end else begin
            w_keep_ok = &s_axis.tkeep;
        end
    end

    assign w_stable_err = pend_q && (!s_axis.tvalid
                                     || (s_axis.tdata != shadow_data_q)
                                     || (s_axis.tkeep != shadow_keep_q)
                                     || (s_axis.tlast != shadow_last_q));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE, C_ST_IN_PKT: begin
                if (w_accept) begin
                    if (s_axis.tlast) begin
                        state_d = w_final ? C_ST_DONE : C_ST_IDLE;
                    end else begin
                        state_d = C_ST_IN_PKT;
                    end
                end
            end
            C_ST_DONE: state_d = C_ST_DONE;
            default:   state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_en = 1'b0;
        w_extra  = 1'b0;
        w_done   = 1'b0;
        case (state_q)
            C_ST_DONE: begin
                w_done  = 1'b1;
                w_extra = w_accept;
            end
            default: w_cnt_en = w_accept;
        endcase
    end

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        last_len_d = last_len_q;
        acc_d      = acc_q;
        if (w_cnt_en) begin
            byte_cnt_d = byte_cnt_q + w_beat_bytes;
            if (s_axis.tlast) begin
                pkt_cnt_d  = pkt_cnt_q + C_CNT_ONE;
                last_len_d = acc_q + w_beat_bytes;
                acc_d      = '0;
            end else begin
                acc_d      = acc_q + w_beat_bytes;
            end
        end
        err_keep_d    = err_keep_q | (w_accept & ~w_keep_ok);
        err_extra_d   = err_extra_q | w_extra;
        err_stable_d  = err_stable_q | w_stable_err;
        pend_d        = s_axis.tvalid & ~tready_q;
        shadow_data_d = pend_d ? s_axis.tdata : shadow_data_q;
        shadow_keep_d = pend_d ? s_axis.tkeep : shadow_keep_q;
        shadow_last_d = pend_d ? s_axis.tlast : shadow_last_q;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lfsr_q        <= C_LFSR_SEED;
            low_cnt_q     <= 2'd0;
            tready_q      <= 1'b0;
            pkt_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            last_len_q    <= '0;
            acc_q         <= '0;
            err_keep_q    <= 1'b0;
            err_stable_q  <= 1'b0;
            err_extra_q   <= 1'b0;
            pend_q        <= 1'b0;
            shadow_data_q <= '0;
            shadow_keep_q <= '0;
            shadow_last_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            low_cnt_q     <= low_cnt_d;
            tready_q      <= tready_d;
            pkt_cnt_q     <= pkt_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            last_len_q    <= last_len_d;
            acc_q         <= acc_d;
            err_keep_q    <= err_keep_d;
            err_stable_q  <= err_stable_d;
            err_extra_q   <= err_extra_d;
            pend_q        <= pend_d;
            shadow_data_q <= shadow_data_d;
            shadow_keep_q <= shadow_keep_d;
            shadow_last_q <= shadow_last_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign DONE          = w_done;
    assign PKT_COUNT     = pkt_cnt_q;
    assign BYTE_COUNT    = byte_cnt_q;
    assign LAST_PKT_LEN  = last_len_q;
    assign ERR_KEEP      = err_keep_q;
    assign ERR_STABLE    = err_stable_q;
    assign ERR_EXTRA     = err_extra_q;
endmodule
`default_nettype wire

// File: tb/tb_axis2net_sink.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis2net_sink : directed + randomized bench, two sink instances   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axis2net_sink;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    axis2net_sink_if #(.C_TDATA_WIDTH(32)) ax0 ();
    axis2net_sink_if #(.C_TDATA_WIDTH(32)) ax1 ();

    logic        done0, ek0, es0, ex0, done1, ek1, es1, ex1;
    logic [31:0] pkt0, bytes0, len0, pkt1, bytes1, len1;

    axis2net_sink #(.C_TDATA_WIDTH(32), .C_NUM_PKTS(2), .C_BP_MODE(0),
                    .C_LFSR_SEED(16'hACE1), .C_CNT_WIDTH(32)) u_dut0 (
        .ACLK(clk), .ARESETN(rst0_n), .s_axis(ax0), .DONE(done0),
        .PKT_COUNT(pkt0), .BYTE_COUNT(bytes0), .LAST_PKT_LEN(len0),
        .ERR_KEEP(ek0), .ERR_STABLE(es0), .ERR_EXTRA(ex0));

    axis2net_sink #(.C_TDATA_WIDTH(32), .C_NUM_PKTS(5), .C_BP_MODE(1),
                    .C_LFSR_SEED(16'hACE1), .C_CNT_WIDTH(32)) u_dut1 (
        .ACLK(clk), .ARESETN(rst1_n), .s_axis(ax1), .DONE(done1),
        .PKT_COUNT(pkt1), .BYTE_COUNT(bytes1), .LAST_PKT_LEN(len1),
        .ERR_KEEP(ek1), .ERR_STABLE(es1), .ERR_EXTRA(ex1));

    // Reference scoreboard, one slot per instance.
    logic [31:0] e_pkts[2], e_bytes[2], e_len[2], e_acc[2];
    logic        e_done[2], e_ek[2], e_es[2], e_ex[2];
    logic [31:0] num_pkts[2] = '{32'd2, 32'd5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] data,
                         input logic [3:0] keep, input logic last);
        if (d == 0) begin
            ax0.tvalid = v; ax0.tdata = data; ax0.tkeep = keep; ax0.tlast = last;
        end else begin
            ax1.tvalid = v; ax1.tdata = data; ax1.tkeep = keep; ax1.tlast = last;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? ax0.tready : ax1.tready;
    endfunction

    task automatic model_reset(input int d);
        e_pkts[d] = '0; e_bytes[d] = '0; e_len[d] = '0; e_acc[d] = '0;
        e_done[d] = 1'b0; e_ek[d] = 1'b0; e_es[d] = 1'b0; e_ex[d] = 1'b0;
    endtask

    task automatic model_accept(input int d, input logic [3:0] keep, input logic last);
        logic [31:0] b;
        logic        legal;
        b     = 32'($countones(keep));
        legal = last ? (keep inside {4'h1, 4'h3, 4'h7, 4'hF}) : (keep == 4'hF);
        if (!legal) e_ek[d] = 1'b1;
        if (e_done[d]) begin
            e_ex[d] = 1'b1;
        end else begin
            e_bytes[d] = e_bytes[d] + b;
            if (last) begin
                e_pkts[d] = e_pkts[d] + 1;
                e_len[d]  = e_acc[d] + b;
                e_acc[d]  = '0;
                if (e_pkts[d] == num_pkts[d]) e_done[d] = 1'b1;
            end else begin
                e_acc[d] = e_acc[d] + b;
            end
        end
    endtask

    task automatic check_all(input int d, input string tag);
        logic [31:0] o_pkt, o_bytes, o_len;
        logic        o_done, o_ek, o_es, o_ex;
        if (d == 0) begin
            o_pkt = pkt0; o_bytes = bytes0; o_len = len0;
            o_done = done0; o_ek = ek0; o_es = es0; o_ex = ex0;
        end else begin
            o_pkt = pkt1; o_bytes = bytes1; o_len = len1;
            o_done = done1; o_ek = ek1; o_es = es1; o_ex = ex1;
        end
        chk({tag, ".pkt"},   o_pkt,   e_pkts[d]);
        chk({tag, ".bytes"}, o_bytes, e_bytes[d]);
        chk({tag, ".len"},   o_len,   e_len[d]);
        chk({tag, ".done"},  32'(o_done), 32'(e_done[d]));
        chk({tag, ".ekeep"}, 32'(o_ek),   32'(e_ek[d]));
        chk({tag, ".estab"}, 32'(o_es),   32'(e_es[d]));
        chk({tag, ".extra"}, 32'(o_ex),   32'(e_ex[d]));
    endtask

    // Presents a beat, holds it unchanged until accepted (bounded wait).
    task automatic send_beat(input int d, input logic [31:0] data,
                             input logic [3:0] keep, input logic last);
        int n = 0;
        drive(d, 1'b1, data, keep, last);
        while (!rdy(d) && n < 40) begin
            tick();
            n++;
        end
        if (!rdy(d)) begin
            chk("ready_timeout", 32'(rdy(d)), 32'd1);
        end else begin
            tick();
            model_accept(d, keep, last);
        end
    endtask

    // Expected TREADY for the backpressured instance: LFSR bit 0, forced
    // high when the three previous cycles were all low.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic fb;
        fb = x[16-16] ^ x[16-14] ^ x[16-13] ^ x[16-11];
        return {fb, x[15:1]};
    endfunction

    logic [15:0] m_lfsr;
    logic [2:0]  m_hist;
    logic        m_tready;
    int          obs_low = 0;

    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin
            m_lfsr   = 16'hACE1;
            m_hist   = 3'b111;
            m_tready = 1'b0;
        end else begin
            m_tready = m_lfsr[0] | (m_hist == 3'b000);
            m_hist   = {m_hist[1:0], m_tready};
            m_lfsr   = lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rst1_n) begin
            chk("m1.tready_model", 32'(ax1.tready), 32'(m_tready));
            obs_low = ax1.tready ? 0 : obs_low + 1;
            chk("m1.tready_lowrun_le3", 32'(obs_low <= 3), 32'd1);
        end else begin
            obs_low = 0;
        end
    end

    initial begin
        int  n;
        logic acc;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 4'h0, 1'b0);
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        chk("rst0.tready", 32'(ax0.tready), 32'd0);
        chk("rst1.tready", 32'(ax1.tready), 32'd0);
        check_all(0, "rst0");
        check_all(1, "rst1");
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        tick();
        chk("m0.tready_up", 32'(ax0.tready), 32'd1);

        // T1: 3-beat packet ending in a 2-byte beat, then a 1-beat packet.
        send_beat(0, $urandom, 4'hF, 1'b0);
        send_beat(0, $urandom, 4'hF, 1'b0);
        send_beat(0, $urandom, 4'h3, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(0, "T1a");
        chk("T1a.len_const", len0, 32'd10);
        send_beat(0, $urandom, 4'hF, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(0, "T1b");
        chk("T1b.len_const", len0, 32'd4);
        chk("T1b.bytes_const", bytes0, 32'd14);
        chk("T1b.done_const", 32'(done0), 32'd1);

        // T5: beat after DONE.
        send_beat(0, $urandom, 4'hF, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(0, "T5");
        chk("T5.pkt_const", pkt0, 32'd2);
        chk("T5.extra_const", 32'(ex0), 32'd1);

        rst0_n = 1'b0;
        model_reset(0);
        tick();
        check_all(0, "rst0b");
        rst0_n = 1'b1;
        tick();

        // T3: illegal TKEEP on both a non-last and a last beat.
        send_beat(0, $urandom, 4'h7, 1'b0);
        check_all(0, "T3a");
        chk("T3a.ekeep_const", 32'(ek0), 32'd1);
        send_beat(0, $urandom, 4'h5, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(0, "T3b");
        chk("T3b.bytes_const", bytes0, 32'd5);

        // T6: asynchronous reset mid-packet.
        send_beat(0, $urandom, 4'hF, 1'b0);
        send_beat(0, $urandom, 4'hF, 1'b0);
        #3;
        rst0_n = 1'b0;
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        model_reset(0);
        #1;
        chk("T6.async_tready", 32'(ax0.tready), 32'd0);
        check_all(0, "T6async");
        tick();
        tick();
        rst0_n = 1'b1;
        tick();
        send_beat(0, $urandom, 4'hF, 1'b0);
        send_beat(0, $urandom, 4'hF, 1'b1);
        drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(0, "T6b");
        chk("T6b.len_const", len0, 32'd8);
        chk("T6b.pkt_const", pkt0, 32'd1);

        // T2: five 64-byte packets under backpressure with random gaps.
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1, 1'b0, $urandom, 4'hF, 1'b0);
                    repeat ($urandom_range(1, 3)) tick();
                end
                send_beat(1, $urandom, 4'hF, (b == 15));
            end
            drive(1, 1'b0, 32'h0, 4'h0, 1'b0);
            check_all(1, $sformatf("T2p%0d", p));
        end
        chk("T2.bytes_const", bytes1, 32'd320);
        chk("T2.done_const", 32'(done1), 32'd1);
        chk("T2.estab_const", 32'(es1), 32'd0);

        rst1_n = 1'b0;
        model_reset(1);
        tick();
        rst1_n = 1'b1;
        tick();

        // T4: data changes while a beat is stalled.
        n = 0;
        while (ax1.tready && n < 100) begin
            tick();
            n++;
        end
        chk("T4.found_low", 32'(ax1.tready), 32'd0);
        drive(1, 1'b1, 32'h1234, 4'hF, 1'b1);
        tick();
        check_all(1, "T4a");
        acc = rdy(1);
        drive(1, 1'b1, 32'h5678, 4'hF, 1'b1);
        tick();
        if (acc) model_accept(1, 4'hF, 1'b1);
        e_es[1] = 1'b1;
        drive(1, 1'b0, 32'h0, 4'h0, 1'b0);
        check_all(1, "T4b");
        chk("T4b.estab_const", 32'(es1), 32'd1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
